// File: rtl/clock_pkg.sv
// Shared definitions for the mm:ss timer: edit-command encodings,
// the BCD digit type and the default prescaler rate.
package clock_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [2:0] {
        OP_NOP       = 3'b000,
        OP_SEC_ZERO  = 3'b001,
        OP_MIN_ADD   = 3'b010,
        OP_CLK_RESET = 3'b011,
        OP_MIN_SUB   = 3'b100
    } op_e;

    localparam int unsigned DEFAULT_TICKS_PER_SEC = 1000;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter, 0..MODULUS-1, with clear/inc/dec (in that priority).
// carry_o/borrow_o flag the wrap in the current cycle's step.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int unsigned MODULUS = 60
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   inc_i,
    input  logic   dec_i,
    input  logic   clr_i,
    output digit_t tens_o,
    output digit_t units_o,
    output logic   carry_o,
    output logic   borrow_o
);

    localparam int unsigned MAX_VAL   = MODULUS - 1;
    localparam digit_t      MAX_TENS  = digit_t'(MAX_VAL / 10);
    localparam digit_t      MAX_UNITS = digit_t'(MAX_VAL % 10);

    digit_t tens_q, tens_d;
    digit_t units_q, units_d;
    logic   at_max, at_zero;

    assign at_max  = (tens_q == MAX_TENS) && (units_q == MAX_UNITS);
    assign at_zero = (tens_q == 4'd0) && (units_q == 4'd0);

    always_comb begin
        tens_d   = tens_q;
        units_d  = units_q;
        carry_o  = 1'b0;
        borrow_o = 1'b0;
        if (clr_i) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
        end else if (inc_i) begin
            if (at_max) begin
                tens_d  = 4'd0;
                units_d = 4'd0;
                carry_o = 1'b1;
            end else if (units_q == 4'd9) begin
                tens_d  = tens_q + 4'd1;
                units_d = 4'd0;
            end else begin
                units_d = units_q + 4'd1;
            end
        end else if (dec_i) begin
            if (at_zero) begin
                tens_d   = MAX_TENS;
                units_d  = MAX_UNITS;
                borrow_o = 1'b1;
            end else if (units_q == 4'd0) begin
                tens_d  = tens_q - 4'd1;
                units_d = 4'd9;
            end else begin
                units_d = units_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens_o  = tens_q;
    assign units_o = units_q;

endmodule

// File: rtl/bcd_minsec_timer.sv
// mm:ss up/down timer: prescaler to a one-second tick, BCD seconds/minutes
// counters, encoder edit commands, run gate and count-down expiry hold.
module bcd_minsec_timer
    import clock_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
    parameter int unsigned MAX_MIN       = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] operation,
    input  logic       run,
    input  logic       dir,
    output logic       encoder_reset,
    output logic [3:0] dis_mX,
    output logic [3:0] dis_mU,
    output logic [3:0] dis_sX,
    output logic [3:0] dis_sU,
    output logic       sec_tick,
    output logic       wrap,
    output logic       expired
);

    localparam int unsigned      PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]    PRESC_TERM = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          hold_q, hold_d;
    logic          sec_tick_q, wrap_q, expired_q, enc_rst_q;
    logic          wrap_d, expired_d;

    logic cmd_sec_zero, cmd_min_add, cmd_clk_reset, cmd_min_sub, cmd_any;
    logic tick_due, at_zero, step, step_up, step_dn;
    logic sec_carry, sec_borrow, min_carry, min_borrow_unused;
    digit_t sec_tens, sec_units, min_tens, min_units;

    always_comb begin
        cmd_sec_zero  = 1'b0;
        cmd_min_add   = 1'b0;
        cmd_clk_reset = 1'b0;
        cmd_min_sub   = 1'b0;
        case (operation)
            OP_SEC_ZERO:  cmd_sec_zero  = 1'b1;
            OP_MIN_ADD:   cmd_min_add   = 1'b1;
            OP_CLK_RESET: cmd_clk_reset = 1'b1;
            OP_MIN_SUB:   cmd_min_sub   = 1'b1;
            default:      ;
        endcase
    end

    assign cmd_any = cmd_sec_zero | cmd_min_add | cmd_clk_reset | cmd_min_sub;

    // Any command restarts the second and swallows a tick due this cycle.
    always_comb begin
        presc_d  = presc_q;
        tick_due = 1'b0;
        if (cmd_any) begin
            presc_d = '0;
        end else if (run) begin
            if (presc_q == PRESC_TERM) begin
                presc_d  = '0;
                tick_due = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    assign at_zero = (min_tens == 4'd0) && (min_units == 4'd0) &&
                     (sec_tens == 4'd0) && (sec_units == 4'd0);
    assign step    = tick_due && !(dir && (hold_q || at_zero));
    assign step_up = step && !dir;
    assign step_dn = step && dir;

    bcd_mod_counter #(.MODULUS(60)) u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    (step_up),
        .dec_i    (step_dn),
        .clr_i    (cmd_sec_zero | cmd_clk_reset),
        .tens_o   (sec_tens),
        .units_o  (sec_units),
        .carry_o  (sec_carry),
        .borrow_o (sec_borrow)
    );

    bcd_mod_counter #(.MODULUS(MAX_MIN + 1)) u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    ((step_up && sec_carry) || cmd_min_add),
        .dec_i    ((step_dn && sec_borrow) || cmd_min_sub),
        .clr_i    (cmd_clk_reset),
        .tens_o   (min_tens),
        .units_o  (min_units),
        .carry_o  (min_carry),
        .borrow_o (min_borrow_unused)
    );

    // minute_add alone never sees a seconds carry, so it cannot raise wrap.
    assign wrap_d    = step_up && sec_carry && min_carry;
    assign expired_d = step_dn && (min_tens == 4'd0) && (min_units == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_units == 4'd1);

    always_comb begin
        hold_d = hold_q;
        if (cmd_any || !dir) begin
            hold_d = 1'b0;
        end else if (expired_d) begin
            hold_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            hold_q     <= 1'b0;
            sec_tick_q <= 1'b0;
            wrap_q     <= 1'b0;
            expired_q  <= 1'b0;
            enc_rst_q  <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            hold_q     <= hold_d;
            sec_tick_q <= step;
            wrap_q     <= wrap_d;
            expired_q  <= expired_d;
            enc_rst_q  <= cmd_any;
        end
    end

    assign encoder_reset = enc_rst_q;
    assign sec_tick      = sec_tick_q;
    assign wrap          = wrap_q;
    assign expired       = expired_q;
    assign dis_mX        = min_tens;
    assign dis_mU        = min_units;
    assign dis_sX        = sec_tens;
    assign dis_sU        = sec_units;

endmodule

// File: tb/tb_bcd_minsec_timer.sv
// Directed bench: instance A (4 ticks/s, 59 min) for up-count and edits,
// instance B (4 ticks/s, 9 min) for count-down, expiry and hold.
module tb_bcd_minsec_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] op_a, op_b;
    logic       run_a, run_b, dir_a, dir_b;
    logic       er_a, st_a, wr_a, ex_a;
    logic       er_b, st_b, wr_b, ex_b;
    logic [3:0] mX_a, mU_a, sX_a, sU_a;
    logic [3:0] mX_b, mU_b, sX_b, sU_b;
    logic [15:0] disp_a, disp_b;

    int n_cmp = 0;
    int n_bad = 0;

    assign disp_a = {mX_a, mU_a, sX_a, sU_a};
    assign disp_b = {mX_b, mU_b, sX_b, sU_b};

    always #5 clk = ~clk;

    bcd_minsec_timer #(.TICKS_PER_SEC(4), .MAX_MIN(59)) dut_a (
        .clk(clk), .rst_n(rst_n), .operation(op_a), .run(run_a), .dir(dir_a),
        .encoder_reset(er_a), .dis_mX(mX_a), .dis_mU(mU_a), .dis_sX(sX_a),
        .dis_sU(sU_a), .sec_tick(st_a), .wrap(wr_a), .expired(ex_a)
    );

    bcd_minsec_timer #(.TICKS_PER_SEC(4), .MAX_MIN(9)) dut_b (
        .clk(clk), .rst_n(rst_n), .operation(op_b), .run(run_b), .dir(dir_b),
        .encoder_reset(er_b), .dis_mX(mX_b), .dis_mU(mU_b), .dis_sX(sX_b),
        .dis_sU(sU_b), .sec_tick(st_b), .wrap(wr_b), .expired(ex_b)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_a = 3'b000; op_b = 3'b000;
        run_a = 1'b0; run_b = 1'b0; dir_a = 1'b0; dir_b = 1'b0;
        #12;
        n_cmp++; if ({disp_a, st_a, wr_a, ex_a, er_a} !== 20'h0) begin n_bad++; $display("FAIL reset_a: got %h want 0", {disp_a, st_a, wr_a, ex_a, er_a}); end
        n_cmp++; if ({disp_b, st_b, wr_b, ex_b, er_b} !== 20'h0) begin n_bad++; $display("FAIL reset_b: got %h want 0", {disp_b, st_b, wr_b, ex_b, er_b}); end
        @(posedge clk); #1;
        run_a = 1'b1;
        rst_n = 1'b1;
        cyc(3);
        n_cmp++; if (st_a !== 1'b0) begin n_bad++; $display("FAIL early_tick: got %b want 0", st_a); end
        n_cmp++; if (disp_a !== 16'h0000) begin n_bad++; $display("FAIL pre_tick_disp: got %h want 0000", disp_a); end
        cyc(1);
        n_cmp++; if (st_a !== 1'b1) begin n_bad++; $display("FAIL first_tick: got %b want 1", st_a); end
        n_cmp++; if (disp_a !== 16'h0001) begin n_bad++; $display("FAIL first_tick_disp: got %h want 0001", disp_a); end
    endtask

    task automatic test_wrap();
        op_a = 3'b010;
        cyc(59);
        n_cmp++; if (disp_a !== 16'h5901) begin n_bad++; $display("FAIL preload_min: got %h want 5901", disp_a); end
        n_cmp++; if (er_a !== 1'b1) begin n_bad++; $display("FAIL preload_ack: got %b want 1", er_a); end
        op_a = 3'b000;
        cyc(1);
        n_cmp++; if (er_a !== 1'b0) begin n_bad++; $display("FAIL ack_drop: got %b want 0", er_a); end
        cyc(231);
        n_cmp++; if (disp_a !== 16'h5959) begin n_bad++; $display("FAIL preload_sec: got %h want 5959", disp_a); end
        n_cmp++; if (wr_a !== 1'b0) begin n_bad++; $display("FAIL early_wrap: got %b want 0", wr_a); end
        cyc(3);
        n_cmp++; if (st_a !== 1'b0) begin n_bad++; $display("FAIL mid_second_tick: got %b want 0", st_a); end
        cyc(1);
        n_cmp++; if (disp_a !== 16'h0000) begin n_bad++; $display("FAIL wrap_disp: got %h want 0000", disp_a); end
        n_cmp++; if ({wr_a, st_a} !== 2'b11) begin n_bad++; $display("FAIL wrap_pulse: got %b want 11", {wr_a, st_a}); end
        cyc(1);
        n_cmp++; if (wr_a !== 1'b0) begin n_bad++; $display("FAIL wrap_width: got %b want 0", wr_a); end
    endtask

    task automatic test_minute_edit();
        cyc(119);
        n_cmp++; if (disp_a !== 16'h0030) begin n_bad++; $display("FAIL reach_0030: got %h want 0030", disp_a); end
        op_a = 3'b100;
        cyc(1);
        n_cmp++; if (disp_a !== 16'h5930) begin n_bad++; $display("FAIL min_sub_wrap: got %h want 5930", disp_a); end
        n_cmp++; if (er_a !== 1'b1) begin n_bad++; $display("FAIL min_sub_ack: got %b want 1", er_a); end
        op_a = 3'b010;
        cyc(1);
        n_cmp++; if (disp_a !== 16'h0030) begin n_bad++; $display("FAIL min_add_wrap: got %h want 0030", disp_a); end
        n_cmp++; if (wr_a !== 1'b0) begin n_bad++; $display("FAIL min_add_no_wrap: got %b want 0", wr_a); end
        op_a = 3'b000;
        cyc(1);
        n_cmp++; if (er_a !== 1'b0) begin n_bad++; $display("FAIL edit_ack_drop: got %b want 0", er_a); end
    endtask

    task automatic test_cmd_vs_tick();
        cyc(2);
        op_a = 3'b010;
        cyc(12);
        op_a = 3'b000;
        cyc(16);
        n_cmp++; if (disp_a !== 16'h1234) begin n_bad++; $display("FAIL reach_1234: got %h want 1234", disp_a); end
        cyc(3);
        op_a = 3'b010;
        cyc(1);
        n_cmp++; if (disp_a !== 16'h1334) begin n_bad++; $display("FAIL cmd_over_tick: got %h want 1334", disp_a); end
        n_cmp++; if (st_a !== 1'b0) begin n_bad++; $display("FAIL tick_discarded: got %b want 0", st_a); end
        op_a = 3'b000;
        cyc(3);
        n_cmp++; if (st_a !== 1'b0) begin n_bad++; $display("FAIL presc_cleared: got %b want 0", st_a); end
        cyc(1);
        n_cmp++; if ({disp_a, st_a} !== {16'h1335, 1'b1}) begin n_bad++; $display("FAIL tick_after_cmd: got %h want 13351", {disp_a, st_a}); end
    endtask

    task automatic test_run_pause();
        cyc(2);
        run_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            n_cmp++; if ({disp_a, st_a} !== {16'h1335, 1'b0}) begin n_bad++; $display("FAIL paused_%0d: got %h want 13350", i, {disp_a, st_a}); end
        end
        run_a = 1'b1;
        cyc(1);
        n_cmp++; if (st_a !== 1'b0) begin n_bad++; $display("FAIL resume_early: got %b want 0", st_a); end
        cyc(1);
        n_cmp++; if ({disp_a, st_a} !== {16'h1336, 1'b1}) begin n_bad++; $display("FAIL resume_tick: got %h want 13361", {disp_a, st_a}); end
    endtask

    task automatic test_async_reset();
        op_a = 3'b011;
        cyc(1);
        n_cmp++; if ({disp_a, er_a} !== {16'h0000, 1'b1}) begin n_bad++; $display("FAIL clock_reset: got %h want 00001", {disp_a, er_a}); end
        op_a = 3'b010;
        cyc(7);
        op_a = 3'b000;
        cyc(180);
        n_cmp++; if (disp_a !== 16'h0745) begin n_bad++; $display("FAIL reach_0745: got %h want 0745", disp_a); end
        cyc(3);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({disp_a, st_a, wr_a, ex_a, er_a} !== 20'h0) begin n_bad++; $display("FAIL async_reset: got %h want 0", {disp_a, st_a, wr_a, ex_a, er_a}); end
        run_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_countdown();
        op_b = 3'b010;
        cyc(1);
        n_cmp++; if ({disp_b, er_b} !== {16'h0100, 1'b1}) begin n_bad++; $display("FAIL b_load_0100: got %h want 01001", {disp_b, er_b}); end
        op_b = 3'b000; dir_b = 1'b1; run_b = 1'b1;
        cyc(4);
        n_cmp++; if ({disp_b, st_b} !== {16'h0059, 1'b1}) begin n_bad++; $display("FAIL borrow_0059: got %h want 00591", {disp_b, st_b}); end
        cyc(232);
        n_cmp++; if ({disp_b, ex_b} !== {16'h0001, 1'b0}) begin n_bad++; $display("FAIL reach_0001: got %h want 00010", {disp_b, ex_b}); end
        cyc(4);
        n_cmp++; if ({disp_b, st_b, ex_b} !== {16'h0000, 2'b11}) begin n_bad++; $display("FAIL expiry: got %h want 0000 1 1", {disp_b, st_b, ex_b}); end
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            n_cmp++; if ({disp_b, st_b, ex_b} !== {16'h0000, 2'b00}) begin n_bad++; $display("FAIL hold_%0d: got %h want 0000 0 0", i, {disp_b, st_b, ex_b}); end
        end
    endtask

    task automatic test_down_edits();
        op_b = 3'b100;
        cyc(1);
        n_cmp++; if ({disp_b, er_b} !== {16'h0900, 1'b1}) begin n_bad++; $display("FAIL b_min_sub_wrap: got %h want 09001", {disp_b, er_b}); end
        op_b = 3'b000;
        cyc(4);
        n_cmp++; if ({disp_b, st_b} !== {16'h0859, 1'b1}) begin n_bad++; $display("FAIL hold_released: got %h want 08591", {disp_b, st_b}); end
        op_b = 3'b001;
        cyc(1);
        n_cmp++; if (disp_b !== 16'h0800) begin n_bad++; $display("FAIL sec_to_zero: got %h want 0800", disp_b); end
        op_b = 3'b101;
        cyc(1);
        n_cmp++; if ({disp_b, er_b} !== {16'h0800, 1'b0}) begin n_bad++; $display("FAIL op101_nop: got %h want 08000", {disp_b, er_b}); end
        op_b = 3'b000;
        cyc(2);
        n_cmp++; if (st_b !== 1'b0) begin n_bad++; $display("FAIL op101_early: got %b want 0", st_b); end
        cyc(1);
        n_cmp++; if ({disp_b, st_b} !== {16'h0759, 1'b1}) begin n_bad++; $display("FAIL op101_keeps_presc: got %h want 07591", {disp_b, st_b}); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_minute_edit();
        test_cmd_vs_tick();
        test_run_pause();
        test_async_reset();
        test_countdown();
        test_down_edits();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_minsec_timer.md
# bcd_minsec_timer

Parametrised mm:ss up/down timer for the FPGA clock display path, the next generation of the fixed 1 kHz minute/second counter. It divides `clk` down to a one-second tick, keeps minutes and seconds as four BCD digits, and accepts encoder-driven edit commands. Beyond the previous counter it supports a configurable tick rate and minute range, count-down mode with expiry, minute decrement, and a run/pause gate. Digit outputs feed the seven-segment scan driver unchanged.

## Interface
- `TICKS_PER_SEC`, 1000: `clk` cycles per second; ≥2.
- `MAX_MIN`, 59: highest minute value; 1..99.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `operation` in 3: edit command, sampled every cycle. 000 nop, 001 sec_to_zero, 010 minute_add, 011 clock_reset, 100 minute_sub, 101..111 treated as nop.
- `run` in 1: 1 = prescaler advances; 0 = paused, prescaler holds.
- `dir` in 1: 0 = count up, 1 = count down.
- `encoder_reset` out 1: registered ack; high the cycle after any cycle with a non-nop `operation`.
- `dis_mX`, `dis_mU`, `dis_sX`, `dis_sU` out 4 each: BCD minute tens/units, second tens/units.
- `sec_tick` out 1: one-cycle pulse on every applied second step.
- `wrap` out 1: one-cycle pulse when up-count rolls MAX_MIN:59 → 00:00.
- `expired` out 1: one-cycle pulse when down-count reaches 00:00.

## Operation
- Reset: all digits 0, prescaler 0, all outputs 0, hold flag clear.
- Prescaler 0..TICKS_PER_SEC-1; advances when `run`=1 and no command; terminal count with `run`=1 produces a tick, and the prescaler returns to 0.
- Tick, `dir`=0: seconds +1; 59 → 00 carries to minutes +1; MAX_MIN → 00 with seconds 59 → 00 pulses `wrap`.
- Tick, `dir`=1: seconds −1; 00 → 59 borrows minutes −1. Step 00:01 → 00:00 pulses `expired` and sets hold. At 00:00 with `dir`=1, ticks are ignored (no `sec_tick`, digits hold). Hold clears on any command or `dir`=0.
- minute_add: minutes +1, MAX_MIN → 00, seconds untouched, no `wrap`.
- minute_sub: minutes −1, 00 → MAX_MIN, seconds untouched.
- sec_to_zero: seconds → 00. clock_reset: all digits → 00.
- Any non-nop command clears the prescaler; a tick due in the same cycle is discarded. Commands take priority over ticks.
- A command held for N cycles is applied N times; `encoder_reset` stays high for N cycles, delayed one cycle. Upstream is responsible for single-cycle commands.
- Digits are always valid BCD; no state reachable from reset yields a digit >9, sX >5, or minutes >MAX_MIN.

## Timing
- All outputs are registered. Digits change on the edge where tick/command is sampled.
- First tick after reset or command: exactly TICKS_PER_SEC cycles with `run`=1.
- `sec_tick`, `wrap`, `expired` are asserted in the same cycle the new digit values appear.
- `run` low mid-second freezes the prescaler; resuming continues from the frozen count.
- A `dir` change takes effect at the next tick; the prescaler is unaffected.
- `rst_n` assertion mid-second or mid-command clears everything immediately. Deassertion must be synchronised upstream.

## Structure
- Shared package `clock_pkg`: op encodings (`OP_NOP`, `OP_SEC_ZERO`, `OP_MIN_ADD`, `OP_CLK_RESET`, `OP_MIN_SUB`), the 4-bit BCD digit type, and the default tick rate constant.
- Sub-module `bcd_mod_counter`, instantiated twice (seconds modulus 60, minutes modulus MAX_MIN+1):
  - Two-digit BCD counter with inc/dec/clear inputs.
  - Carry-out on wrap up, borrow-out on wrap down.
  - Combinational next-state with registered digits.

## Test plan
- TICKS_PER_SEC=4, MAX_MIN=59, `run`=1, `dir`=0 from reset: after 4 cycles `sec_tick` pulses and display is 00:01. Preload 59:59 via 59 minute_add plus ticks; next tick → 00:00 with `wrap`=1.
- MAX_MIN=9, `dir`=1, display 01:00: tick → 00:59. Continue to 00:01 → 00:00 with `expired`=1, then 8 further cycles hold 00:00 with no `sec_tick`.
- minute_sub at 00:30 (MAX_MIN=59) → 59:30 and `encoder_reset`=1 next cycle. minute_add at 59:30 → 00:30 with no `wrap`.
- minute_add in the same cycle as a due tick at 12:34 → 13:34, prescaler 0, next tick 4 cycles later → 13:35.
- `run`=0 for 10 cycles at prescaler=2: digits and prescaler frozen. Resume: tick after 2 more cycles.
- Assert `rst_n` low mid-count at 07:45, prescaler=3: all outputs 0 immediately, before the next `clk` edge.
